calc_seq_ctrl: RTL

Sequencing controller for the calculator datapath. It sits between the debounced keypad-cursor selection logic and the operand digit registers / ALU. It turns one-cycle key events into digit-shift and clear strobes for operands A and B, latches the operator, and launches the ALU with a start/done handshake. It also tracks result display, error and chained-operation state for the VGA renderer.

---
 rtl/calc_seq_ctrl_if.sv | 35 +++
 rtl/calc_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl_if.sv
// Calculator sequencer bus: keypad events and ALU handshake in, register strobes and display state out.
// Latency: none, wires only.
// Backpressure: none; key and ALU events are one-cycle pulses that must be consumed when presented.
interface calc_seq_ctrl_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic       alu_done;
    logic       alu_err;
    logic       a_shift;
    logic       b_shift;
    logic [3:0] digit_out;
    logic       a_clr;
    logic       b_clr;
    logic       res_to_a;
    logic [2:0] op_code;
    logic       alu_start;
    logic       show_result;
    logic       err;
    logic       busy;
    logic [2:0] state_dbg;

    // Controller side
    modport master (
        input  key_valid, key_code, alu_done, alu_err,
        output a_shift, b_shift, digit_out, a_clr, b_clr, res_to_a,
               op_code, alu_start, show_result, err, busy, state_dbg
    );

    // Keypad / ALU / display side
    modport slave (
        output key_valid, key_code, alu_done, alu_err,
        input  a_shift, b_shift, digit_out, a_clr, b_clr, res_to_a,
               op_code, alu_start, show_result, err, busy, state_dbg
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: turns key pulses into operand strobes, latches the operator and runs the ALU handshake.
// Latency: every output is registered; a key at cycle N shows its strobes at N+1, alu_start follows EXEC by one cycle.
// Backpressure: none; keys outside their accepting states are dropped, ALU wait is bounded by TIMEOUT cycles.
module calc_seq_ctrl #(
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic           CLK,
    input  logic           RST,
    calc_seq_ctrl_if.master bus
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_ENT_A = 3'd0,
        ST_ENT_B = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SHOW  = 3'd4,
        ST_ERR   = 3'd5,
        ST_LOAD  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] a_cnt_q, a_cnt_d;
    logic [CW-1:0] b_cnt_q, b_cnt_d;
    logic [2:0]    op_q, op_d;
    logic [3:0]    pend_q, pend_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          a_shift_q, a_shift_d;
    logic          b_shift_q, b_shift_d;
    logic [3:0]    digit_q, digit_d;
    logic          a_clr_q, a_clr_d;
    logic          b_clr_q, b_clr_d;
    logic          res_to_a_q, res_to_a_d;
    logic          alu_start_q, alu_start_d;
    logic          show_q, show_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic       is_digit, is_op, is_sqrt, is_eq, is_clr;
    logic [2:0] key_op;

    // Key classification; codes 17..31 match nothing and fall through as no-ops
    always_comb begin
        is_digit = bus.key_valid && (bus.key_code <= 5'd9);
        is_op    = bus.key_valid && (bus.key_code >= 5'd10) && (bus.key_code <= 5'd13);
        is_sqrt  = bus.key_valid && (bus.key_code == 5'd14);
        is_eq    = bus.key_valid && (bus.key_code == 5'd15);
        is_clr   = bus.key_valid && (bus.key_code == 5'd16);
        // codes 10..13 have low bits 2..5, so subtracting 2 yields add/sub/mul/div = 0..3
        key_op   = bus.key_code[2:0] - 3'd2;
    end

    // Next-state and registered-output computation; clear overrides everything, including a same-cycle alu_done
    always_comb begin
        state_d     = state_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        op_d        = op_q;
        pend_d      = pend_q;
        tmo_d       = tmo_q;
        digit_d     = digit_q;
        a_shift_d   = 1'b0;
        b_shift_d   = 1'b0;
        a_clr_d     = 1'b0;
        b_clr_d     = 1'b0;
        res_to_a_d  = 1'b0;
        alu_start_d = 1'b0;

        if (is_clr) begin
            a_clr_d = 1'b1;
            b_clr_d = 1'b1;
            a_cnt_d = '0;
            b_cnt_d = '0;
            op_d    = 3'd0;
            state_d = ST_ENT_A;
        end else begin
            unique case (state_q)
                ST_ENT_A: begin
                    if (is_digit && (a_cnt_q < CNT_MAX)) begin
                        a_shift_d = 1'b1;
                        digit_d   = bus.key_code[3:0];
                        a_cnt_d   = a_cnt_q + CW'(1);
                    end else if (is_op) begin
                        op_d    = key_op;
                        b_clr_d = 1'b1;
                        b_cnt_d = '0;
                        state_d = ST_ENT_B;
                    end else if (is_sqrt) begin
                        op_d    = 3'd4;
                        state_d = ST_EXEC;
                    end
                end
                ST_ENT_B: begin
                    if (is_digit && (b_cnt_q < CNT_MAX)) begin
                        b_shift_d = 1'b1;
                        digit_d   = bus.key_code[3:0];
                        b_cnt_d   = b_cnt_q + CW'(1);
                    end else if (is_op && (b_cnt_q == '0)) begin
                        op_d = key_op;
                    end else if (is_eq && (b_cnt_q != '0)) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_start_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    // a done on the final timeout cycle still counts as a completion
                    if (bus.alu_done) begin
                        state_d = bus.alu_err ? ST_ERR : ST_SHOW;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                ST_SHOW: begin
                    if (is_digit) begin
                        // start a fresh calculation; the digit is replayed into A from LOAD
                        a_clr_d = 1'b1;
                        b_clr_d = 1'b1;
                        a_cnt_d = '0;
                        b_cnt_d = '0;
                        pend_d  = bus.key_code[3:0];
                        state_d = ST_LOAD;
                    end else if (is_op) begin
                        // chain: result becomes A and is treated as full so no digits append to it
                        res_to_a_d = 1'b1;
                        a_cnt_d    = CNT_MAX;
                        op_d       = key_op;
                        b_clr_d    = 1'b1;
                        b_cnt_d    = '0;
                        state_d    = ST_ENT_B;
                    end else if (is_sqrt) begin
                        res_to_a_d = 1'b1;
                        op_d       = 3'd4;
                        state_d    = ST_EXEC;
                    end
                end
                ST_LOAD: begin
                    a_shift_d = 1'b1;
                    digit_d   = pend_q;
                    a_cnt_d   = CW'(1);
                    state_d   = ST_ENT_A;
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_ENT_A;
                end
            endcase
        end

        show_d = (state_d == ST_SHOW);
        err_d  = (state_d == ST_ERR);
        busy_d = (state_d == ST_EXEC) || (state_d == ST_WAIT);
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_ENT_A;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            op_q        <= 3'd0;
            pend_q      <= 4'd0;
            tmo_q       <= '0;
            digit_q     <= 4'd0;
            a_shift_q   <= 1'b0;
            b_shift_q   <= 1'b0;
            a_clr_q     <= 1'b0;
            b_clr_q     <= 1'b0;
            res_to_a_q  <= 1'b0;
            alu_start_q <= 1'b0;
            show_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            op_q        <= op_d;
            pend_q      <= pend_d;
            tmo_q       <= tmo_d;
            digit_q     <= digit_d;
            a_shift_q   <= a_shift_d;
            b_shift_q   <= b_shift_d;
            a_clr_q     <= a_clr_d;
            b_clr_q     <= b_clr_d;
            res_to_a_q  <= res_to_a_d;
            alu_start_q <= alu_start_d;
            show_q      <= show_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.a_shift     = a_shift_q;
    assign bus.b_shift     = b_shift_q;
    assign bus.digit_out   = digit_q;
    assign bus.a_clr       = a_clr_q;
    assign bus.b_clr       = b_clr_q;
    assign bus.res_to_a    = res_to_a_q;
    assign bus.op_code     = op_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.show_result = show_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.state_dbg   = state_q;

endmodule
